// File: rtl/phy_tx_byte_if.sv
// PHY-side transmit byte interface: start/end handshake, toggle byte pull into a
// two-entry buffer, and LSB-first bit serializer with sof/eof/underrun flags.
module phy_tx_byte_if #(
  parameter int unsigned BIT_DIV      = 4,
  parameter int unsigned PREAMBLE_CYC = 1536
) (
  input  logic        clk_80m,
  input  logic        bus_clk_resetn,
  input  logic        phy_txstartend_req,
  input  logic        phy_data_req,
  input  logic [7:0]  bup_txdata,
  input  logic [11:0] txv_length_reg,
  input  logic        txv_immstop,
  output logic        phy_txstartend_conf,
  output logic        phy_data_conf,
  output logic        tx_bit,
  output logic        tx_bit_valid,
  output logic        tx_sof_p,
  output logic        tx_eof_p,
  output logic        tx_underrun,
  output logic [11:0] tx_byte_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_END      = 2'd3
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_CYC - 1);
  localparam logic [7:0]  DIV_LAST = 8'(BIT_DIV - 1);

  state_t      state_q, state_d;
  logic        req_q1, req_q2, data_req_q;
  logic [11:0] len_q, req_cnt;
  logic        outstanding;
  logic [7:0]  fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  occ;
  logic [15:0] pre_cnt;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  rd_data;
  logic [11:0] byte_cnt_inc;

  logic start, active, abort, pre_done, period_end, byte_end, bit_adv;
  logic frame_done, boundary, pop, starve, capture, issue, flush;

  // Byte handshake: the conf rising edge requests byte 0, every phy_data_conf
  // toggle requests one more; each phy_data_req toggle delivers one byte on
  // bup_txdata. Only one request is ever outstanding.
  always_comb begin
    rd_data      = fifo_mem[rd_ptr];
    byte_cnt_inc = tx_byte_cnt + 12'd1;
    start        = (state_q == S_IDLE) && req_q1 && !req_q2 && (txv_length_reg != 12'd0);
    active       = (state_q == S_PREAMBLE) || (state_q == S_DATA);
    abort        = txv_immstop && (state_q != S_IDLE);
    pre_done     = (state_q == S_PREAMBLE) && (pre_cnt == PRE_LAST) && !abort;
    period_end   = (state_q == S_DATA) && (div_cnt == DIV_LAST) && !abort;
    byte_end     = period_end && (bit_idx == 3'd7);
    bit_adv      = period_end && (bit_idx != 3'd7);
    frame_done   = byte_end && (byte_cnt_inc == len_q);
    boundary     = pre_done || byte_end;
    pop          = boundary && !frame_done && (occ != 2'd0);
    starve       = boundary && !frame_done && (occ == 2'd0);
    capture      = active && !abort && (phy_data_req != data_req_q) && ((occ != 2'd2) || pop);
    issue        = active && !abort && !starve && !frame_done && !outstanding &&
                   (occ != 2'd2) && (req_cnt < len_q);
    flush        = !active || abort || frame_done || starve;

    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_PREAMBLE;
      S_PREAMBLE: if (pre_done) state_d = starve ? S_END : S_DATA;
      S_DATA:     if (frame_done || starve) state_d = S_END;
      S_END:      if (!phy_txstartend_req) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk_80m or negedge bus_clk_resetn) begin
    if (!bus_clk_resetn) begin
      state_q       <= S_IDLE;
      req_q1        <= 1'b0;
      req_q2        <= 1'b0;
      data_req_q    <= 1'b0;
      len_q         <= 12'd0;
      req_cnt       <= 12'd0;
      outstanding   <= 1'b0;
      fifo_mem[0]   <= 8'd0;
      fifo_mem[1]   <= 8'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
      pre_cnt       <= 16'd0;
      div_cnt       <= 8'd0;
      bit_idx       <= 3'd0;
      shreg         <= 8'd0;
      phy_data_conf <= 1'b0;
      tx_bit_valid  <= 1'b0;
      tx_sof_p      <= 1'b0;
      tx_eof_p      <= 1'b0;
      tx_underrun   <= 1'b0;
      tx_byte_cnt   <= 12'd0;
    end else begin
      state_q      <= state_d;
      req_q1       <= phy_txstartend_req;
      req_q2       <= req_q1;
      data_req_q   <= phy_data_req;
      tx_bit_valid <= 1'b0;
      tx_sof_p     <= 1'b0;
      tx_eof_p     <= 1'b0;

      if (start) begin
        len_q       <= txv_length_reg;
        tx_byte_cnt <= 12'd0;
        tx_underrun <= 1'b0;
        req_cnt     <= 12'd1;
        outstanding <= 1'b1;
        pre_cnt     <= 16'd0;
      end else begin
        if (state_q == S_PREAMBLE) pre_cnt <= pre_cnt + 16'd1;
        if (flush) begin
          outstanding <= 1'b0;
        end else if (issue) begin
          outstanding   <= 1'b1;
          req_cnt       <= req_cnt + 12'd1;
          phy_data_conf <= ~phy_data_conf;
        end else if (capture) begin
          outstanding <= 1'b0;
        end
        if (starve)   tx_underrun <= 1'b1;
        if (byte_end) tx_byte_cnt <= byte_cnt_inc;
      end

      if (flush) begin
        occ    <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (capture) begin
          fifo_mem[wr_ptr] <= bup_txdata;
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        if (capture && !pop)      occ <= occ + 2'd1;
        else if (pop && !capture) occ <= occ - 2'd1;
      end

      // shreg[0] is the bit on the wire; it is zeroed whenever DATA is left.
      if (pop) begin
        shreg        <= rd_data;
        tx_bit_valid <= 1'b1;
        tx_sof_p     <= (state_q == S_PREAMBLE);
        bit_idx      <= 3'd0;
        div_cnt      <= 8'd0;
      end else if (bit_adv) begin
        shreg        <= {1'b0, shreg[7:1]};
        tx_bit_valid <= 1'b1;
        tx_eof_p     <= (bit_idx == 3'd6) && (byte_cnt_inc == len_q);
        bit_idx      <= bit_idx + 3'd1;
        div_cnt      <= 8'd0;
      end else if (state_q == S_DATA) begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (state_d != S_DATA) shreg <= 8'd0;
    end
  end

  assign tx_bit              = shreg[0];
  assign phy_txstartend_conf = (state_q == S_PREAMBLE) || (state_q == S_DATA);
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_phy_tx_byte_if.sv
// Self-checking bench for phy_tx_byte_if: a frame-level model predicts the bit
// stream, its timing, flags and request count from length, supplied bytes and latency.
module tb_phy_tx_byte_if;

  localparam int BD  = 4;
  localparam int PRE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phy_txstartend_req;
  logic        phy_data_req;
  logic [7:0]  bup_txdata;
  logic [11:0] txv_length_reg;
  logic        txv_immstop;
  logic        phy_txstartend_conf;
  logic        phy_data_conf;
  logic        tx_bit;
  logic        tx_bit_valid;
  logic        tx_sof_p;
  logic        tx_eof_p;
  logic        tx_underrun;
  logic [11:0] tx_byte_cnt;
  logic [1:0]  state_dbg;

  phy_tx_byte_if #(.BIT_DIV(BD), .PREAMBLE_CYC(PRE)) dut (
    .clk_80m             (clk),
    .bus_clk_resetn      (rst_n),
    .phy_txstartend_req  (phy_txstartend_req),
    .phy_data_req        (phy_data_req),
    .bup_txdata          (bup_txdata),
    .txv_length_reg      (txv_length_reg),
    .txv_immstop         (txv_immstop),
    .phy_txstartend_conf (phy_txstartend_conf),
    .phy_data_conf       (phy_data_conf),
    .tx_bit              (tx_bit),
    .tx_bit_valid        (tx_bit_valid),
    .tx_sof_p            (tx_sof_p),
    .tx_eof_p            (tx_eof_p),
    .tx_underrun         (tx_underrun),
    .tx_byte_cnt         (tx_byte_cnt),
    .state_dbg           (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] src_bytes[$];
  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];
  logic       obs_bit_q[$];
  int         obs_cyc_q[$];
  logic       obs_sof_q[$];
  logic       obs_eof_q[$];
  int         rise_cyc, fall_cyc, n_toggle, hold_err, stray;
  logic       last_bit;
  logic       mon_conf_prev = 1'b0, mon_dconf_prev = 1'b0;

  int   resp_lat = 1;
  int   resp_timer = 0;
  logic resp_en = 1'b0;
  logic rsp_conf_prev = 1'b0, rsp_dconf_prev = 1'b0;

  typedef struct {
    int len;
    int supply;
    int lat;
    int exp_bits;
    int exp_underrun;
    int exp_cnt;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (phy_txstartend_conf && !mon_conf_prev) rise_cyc = cyc;
      if (!phy_txstartend_conf && mon_conf_prev) fall_cyc = cyc;
      if (phy_data_conf != mon_dconf_prev) n_toggle++;
      if (tx_bit_valid) begin
        obs_bit_q.push_back(tx_bit);
        obs_cyc_q.push_back(cyc);
        obs_sof_q.push_back(tx_sof_p);
        obs_eof_q.push_back(tx_eof_p);
        last_bit = tx_bit;
      end else begin
        if (tx_sof_p || tx_eof_p) stray++;
        if (phy_txstartend_conf && obs_bit_q.size() > 0 && tx_bit !== last_bit) hold_err++;
      end
    end
    mon_conf_prev  = phy_txstartend_conf;
    mon_dconf_prev = phy_data_conf;
  end

  // ---------------- upstream responder (driver) ----------------
  always @(negedge clk) begin
    if (!rst_n || !resp_en) begin
      resp_timer = 0;
    end else begin
      if (resp_timer > 0) begin
        resp_timer--;
        if (resp_timer == 0 && byte_q.size() > 0) begin
          bup_txdata   = byte_q.pop_front();
          phy_data_req = ~phy_data_req;
        end
      end
      if (phy_txstartend_conf && (!rsp_conf_prev || phy_data_conf != rsp_dconf_prev) &&
          byte_q.size() > 0)
        resp_timer = resp_lat;
    end
    rsp_conf_prev  = phy_txstartend_conf;
    rsp_dconf_prev = phy_data_conf;
  end

  // ---------------- driver tasks ----------------
  task automatic fill_src(input int len);
    src_bytes.delete();
    for (int k = 0; k < len; k++) src_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic prep_frame(input int len, input int supply, input int lat);
    byte_q.delete();
    exp_q.delete();
    for (int k = 0; k < len; k++)
      if (k < supply) begin
        byte_q.push_back(src_bytes[k]);
        exp_q.push_back(src_bytes[k]);
      end
    obs_bit_q.delete();
    obs_cyc_q.delete();
    obs_sof_q.delete();
    obs_eof_q.delete();
    rise_cyc = -1;
    fall_cyc = -1;
    n_toggle = 0;
    hold_err = 0;
    stray    = 0;
    txv_length_reg = 12'(len);
    resp_lat = lat;
    resp_en  = 1'b1;
  endtask

  task automatic wait_conf(input logic level, input int budget, input string name);
    int i = 0;
    while (phy_txstartend_conf !== level && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, int'(phy_txstartend_conf), int'(level));
  endtask

  task automatic wait_valids(input int count, input int budget, input string name);
    int nv = 0;
    int i = 0;
    while (nv < count && i < budget) begin
      @(negedge clk);
      i++;
      if (tx_bit_valid) nv++;
    end
    chk(name, nv, count);
  endtask

  task automatic check_frame(input string tag, input int len, input int supply,
                             input int exp_bits, input int exp_underrun, input int exp_cnt);
    int lim;
    logic [7:0] eb;
    chk({tag, " nbits"}, obs_bit_q.size(), exp_bits);
    chk({tag, " underrun"}, int'(tx_underrun), exp_underrun);
    chk({tag, " byte_cnt"}, int'(tx_byte_cnt), exp_cnt);
    chk({tag, " conf_fall_cyc"}, fall_cyc, rise_cyc + PRE + exp_bits * BD);
    chk({tag, " toggles"}, n_toggle, (supply < len) ? supply : len - 1);
    chk({tag, " bit_hold"}, hold_err, 0);
    chk({tag, " stray_flag"}, stray, 0);
    lim = (obs_bit_q.size() < exp_bits) ? obs_bit_q.size() : exp_bits;
    for (int j = 0; j < lim; j++) begin
      eb = exp_q[j / 8];
      chk($sformatf("%s bit%0d", tag, j), int'(obs_bit_q[j]), int'(eb[j % 8]));
      chk($sformatf("%s cyc%0d", tag, j), obs_cyc_q[j], rise_cyc + PRE + j * BD);
      chk($sformatf("%s sof%0d", tag, j), int'(obs_sof_q[j]), (j == 0) ? 1 : 0);
      chk($sformatf("%s eof%0d", tag, j), int'(obs_eof_q[j]),
          (exp_underrun == 0 && j == exp_bits - 1) ? 1 : 0);
    end
  endtask

  task automatic run_frame(input string tag, input int len, input int supply, input int lat,
                           input int exp_bits, input int exp_underrun, input int exp_cnt,
                           input bit drop_early);
    int i;
    prep_frame(len, supply, lat);
    @(negedge clk);
    phy_txstartend_req = 1'b1;
    wait_conf(1'b1, 10, {tag, " conf_rise"});
    if (drop_early) begin
      i = 0;
      while (byte_q.size() > 0 && i < 40) begin
        @(negedge clk);
        i++;
      end
      chk({tag, " byte0_delivered"}, byte_q.size(), 0);
      @(negedge clk);
      phy_txstartend_req = 1'b0;
    end
    wait_conf(1'b0, PRE + 8 * len * BD + 40, {tag, " conf_fall"});
    @(negedge clk);
    chk({tag, " state_after_frame"}, int'(state_dbg), drop_early ? 0 : 3);
    phy_txstartend_req = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " state_idle"}, int'(state_dbg), 0);
    check_frame(tag, len, supply, exp_bits, exp_underrun, exp_cnt);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int len, sup, lat, n;
    int nv, conf_seen;
    int stream;

    vt[0] = '{3, 3, 2, 24, 0, 3};
    vt[1] = '{3, 1, 2,  8, 1, 1};
    vt[2] = '{1, 1, 1,  8, 0, 1};
    vt[3] = '{2, 0, 1,  0, 1, 0};
    vt[4] = '{4, 4, 9, 32, 0, 4};
    vt[5] = '{5, 3, 3, 24, 1, 3};

    rst_n = 1'b0;
    phy_txstartend_req = 1'b0;
    phy_data_req = 1'b0;
    bup_txdata = 8'd0;
    txv_length_reg = 12'd0;
    txv_immstop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset outputs", int'({phy_txstartend_conf, phy_data_conf, tx_bit, tx_bit_valid,
                               tx_sof_p, tx_eof_p, tx_underrun, tx_byte_cnt}), 0);
    chk("reset state", int'(state_dbg), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference frame with fixed bytes and its exact bit string.
    src_bytes = '{8'hA5, 8'h3C, 8'hFF};
    run_frame("ref", 3, 3, 2, 24, 0, 3, 1'b0);
    stream = 0;
    foreach (obs_bit_q[j]) stream = (stream << 1) | int'(obs_bit_q[j]);
    chk("ref stream", stream, 32'h00A53CFF);

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      fill_src(vt[v].len);
      run_frame($sformatf("vec%0d", v), vt[v].len, vt[v].supply, vt[v].lat,
                vt[v].exp_bits, vt[v].exp_underrun, vt[v].exp_cnt, 1'b0);
    end

    // Length 1, request dropped right after byte 0 is delivered.
    fill_src(1);
    run_frame("len1_drop", 1, 1, 2, 8, 0, 1, 1'b1);

    // Length 0: request ignored.
    prep_frame(0, 0, 1);
    @(negedge clk);
    phy_txstartend_req = 1'b1;
    conf_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (phy_txstartend_conf) conf_seen = 1;
    end
    chk("len0 conf", conf_seen, 0);
    chk("len0 toggles", n_toggle, 0);
    chk("len0 state", int'(state_dbg), 0);
    phy_txstartend_req = 1'b0;
    repeat (3) @(negedge clk);

    // Immediate stop during the 5th data bit.
    fill_src(4);
    prep_frame(4, 4, 2);
    @(negedge clk);
    phy_txstartend_req = 1'b1;
    wait_valids(5, PRE + 100, "immstop reach bit5");
    txv_immstop = 1'b1;
    resp_en = 1'b0;
    @(negedge clk);
    chk("immstop conf", int'(phy_txstartend_conf), 0);
    chk("immstop valid", int'(tx_bit_valid), 0);
    chk("immstop state", int'(state_dbg), 0);
    txv_immstop = 1'b0;
    repeat (2) @(negedge clk);
    bup_txdata = 8'h5A;
    phy_data_req = ~phy_data_req;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_bit_valid || tx_eof_p) nv++;
    end
    chk("immstop no_more_bits", nv, 0);
    chk("immstop underrun", int'(tx_underrun), 0);
    chk("immstop conf_low", int'(phy_txstartend_conf), 0);
    phy_txstartend_req = 1'b0;
    repeat (3) @(negedge clk);
    fill_src(2);
    run_frame("post_abort", 2, 2, 3, 16, 0, 2, 1'b0);

    // Randomized frames against the frame-level model.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 6);
      sup = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : len;
      lat = $urandom_range(1, 10);
      n   = (sup < len) ? sup : len;
      fill_src(len);
      run_frame($sformatf("rand%0d", r), len, sup, lat, 8 * n, (sup < len) ? 1 : 0, n, 1'b0);
    end

    // Asynchronous reset in the middle of DATA.
    fill_src(3);
    prep_frame(3, 3, 2);
    @(negedge clk);
    phy_txstartend_req = 1'b1;
    wait_valids(3, PRE + 100, "rst reach bit3");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async outputs", int'({phy_txstartend_conf, phy_data_conf, tx_bit, tx_bit_valid,
                                   tx_sof_p, tx_eof_p, tx_underrun, tx_byte_cnt}), 0);
    chk("rst async state", int'(state_dbg), 0);
    phy_txstartend_req = 1'b0;
    resp_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst release state", int'(state_dbg), 0);
    chk("rst release underrun", int'(tx_underrun), 0);
    chk("rst release conf", int'(phy_txstartend_conf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phy_tx_byte_if.md
# phy_tx_byte_if

PHY-side transmit byte interface sitting directly downstream of the MAC TX adaptation stage in the clk_80m domain. It answers phy_txstartend_req with phy_txstartend_conf and pulls frame bytes from upstream over the toggle handshake (phy_data_conf / phy_data_req + bup_txdata). It buffers up to two bytes and serializes them LSB-first into a timed bit stream for the PHY modulator, flagging underrun and frame boundaries.

## Interface
Parameters:
- BIT_DIV, 4: clk_80m cycles per output bit (2..255).
- PREAMBLE_CYC, 1536: cycles from conf rise to first data bit (16-bit, ≥ 8).

Ports:
- clk_80m  in  1  sole clock.
- bus_clk_resetn  in  1  reset; asynchronous, active-low.
- phy_txstartend_req  in  1  frame start request from upstream; level.
- phy_data_req  in  1  toggle; each edge = one byte valid on bup_txdata.
- bup_txdata  in  8  byte from upstream, stable while phy_data_req is stable.
- txv_length_reg  in  12  frame length in bytes.
- txv_immstop  in  1  immediate abort, level.
- phy_txstartend_conf  out  1  frame active confirm.
- phy_data_conf  out  1  toggle; each edge requests one more byte.
- tx_bit  out  1  serialized data bit.
- tx_bit_valid  out  1  one-cycle strobe per bit.
- tx_sof_p  out  1  pulse with first data bit.
- tx_eof_p  out  1  pulse with last data bit.
- tx_underrun  out  1  sticky; cleared at next frame start.
- tx_byte_cnt  out  12  bytes fully serialized this frame.

## Operation
- Reset: all outputs 0, state IDLE, buffer empty, internal phy_data_req history = 0.
- States: IDLE, PREAMBLE, DATA, END.
- IDLE -> PREAMBLE on phy_txstartend_req rising edge (registered previous value) with txv_length_reg != 0. On this transition: latch length, clear tx_byte_cnt/tx_underrun/request count, set phy_txstartend_conf. If length == 0, the request is ignored.
- The conf rising edge is the implicit request for byte 0. Each later byte is requested by toggling phy_data_conf.
- Request rule:
  - At most one request is outstanding.
  - A new request is issued only when the buffer has a free slot (counting the outstanding byte) and bytes requested < latched length.
- Capture: a phy_data_req edge detected in PREAMBLE/DATA writes bup_txdata into the buffer in the same cycle. Edges in IDLE/END are discarded.
- PREAMBLE: count PREAMBLE_CYC cycles, then enter DATA.
- DATA:
  - A bit period is BIT_DIV cycles; tx_bit is held for the whole period, and tx_bit_valid pulses in its first cycle.
  - At each byte boundary, pop a buffered byte and shift it out bit0 first. tx_sof_p accompanies bit0 of byte 0.
  - After bit7, tx_byte_cnt increments.
  - When tx_byte_cnt reaches the latched length: tx_eof_p pulses with bit7, then go to END.
  - Byte boundary with buffer empty and count < length: set tx_underrun, no eof, go to END.
- END: phy_txstartend_conf = 0, buffer flushed. Go to IDLE when phy_txstartend_req is low.
- phy_txstartend_req falling during PREAMBLE/DATA is ignored; completion is decided by byte count only.
- txv_immstop high in any non-IDLE state: next cycle conf = 0, tx_bit_valid = 0, buffer flushed, go to IDLE. No eof, no underrun.
- txv_length_reg changes mid-frame are ignored.
- Simultaneous pop and capture in one cycle is legal; occupancy stays unchanged.

## Timing
- phy_txstartend_conf rises 1 cycle after the registered req edge, i.e. 2 cycles after phy_txstartend_req goes high.
- First tx_bit_valid occurs exactly PREAMBLE_CYC cycles after conf rises. Byte 0 must arrive before then, otherwise underrun.
- A request toggle is issued ≥ 1 cycle after the condition holds. Upstream response latency may be arbitrary but must be < 8*BIT_DIV cycles to avoid underrun.
- tx_eof_p and the final tx_bit_valid share a cycle; conf falls BIT_DIV cycles later (END entry at end of last bit period).
- Throughput: 1 bit per BIT_DIV cycles, with no gap between bytes when the buffer is non-empty.

## Test plan
- Length 3, BIT_DIV 4, PREAMBLE_CYC 16, bytes A5,3C,FF, upstream answering in 2 cycles -> 24 valids spaced 4 cycles; bit stream 1010010100111100 11111111; sof on the first valid, eof on the 24th; tx_byte_cnt = 3; conf low 4 cycles later.
- Same frame, upstream withholds byte 1 -> tx_underrun = 1 at the byte-1 boundary, no eof, conf low, IDLE after req falls.
- txv_immstop asserted on the 5th data bit -> next cycle conf = 0 and no further valids; a later phy_data_req toggle is ignored; a new frame runs cleanly.
- req rises with length 0 -> conf stays 0 and no toggles occur.
- Length 1, req dropped by upstream immediately after byte 0 delivery -> all 8 bits sent and eof pulses.
- Reset asserted mid-DATA -> all outputs 0 asynchronously; after release, state IDLE and tx_underrun = 0.
